// File: rtl/bnn_maxpool_seq_pkg.sv
// bnn_pkg: shared types and sizing helpers for the binary max-pool stage
package bnn_pkg;
    typedef enum logic [1:0] {IDLE, POOL, DONE} pool_state_t;
    localparam int POOL_K = 2;
    function automatic int pool_out_size(input int in_size);
        return in_size / POOL_K;
    endfunction
endpackage

// File: rtl/bnn_maxpool_seq_if.sv
// bnn_maxpool_seq_if: bitmap-in / pooled-bitmap-out handshake bundle
interface bnn_maxpool_seq_if #(
    parameter int M = 28
);
    localparam int N = bnn_pkg::pool_out_size(M);
    logic             data_in_ready;
    logic [M*M-1:0]   img_in;
    logic [N*N-1:0]   img_out;
    logic             data_out_ready;
    logic             busy;
    modport master (output data_in_ready, img_in, input img_out, data_out_ready, busy);
    modport slave  (input data_in_ready, img_in, output img_out, data_out_ready, busy);
endinterface

// File: rtl/bnn_maxpool_seq.sv
// bnn_maxpool_seq: serial 2x2 stride-2 binary max-pool, one output pixel per clock
module bnn_maxpool_seq
    import bnn_pkg::*;
#(
    parameter int IMG_IN_SIZE  = 28,
    parameter int IMG_OUT_SIZE = pool_out_size(IMG_IN_SIZE)
) (
    input  logic               clk,
    input  logic               rst,
    bnn_maxpool_seq_if.slave   bus
);
    localparam int M  = IMG_IN_SIZE;
    localparam int N  = IMG_OUT_SIZE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int IW = (N * N > 1) ? $clog2(N * N) : 1;

    pool_state_t      r_state;
    logic [CW-1:0]    r_row, r_col;
    logic [M*M-1:0]   r_buf;
    logic [N*N-1:0]   r_img_out;
    logic             r_dor, r_busy;
    logic [N*N-1:0]   w_pool;
    logic [IW-1:0]    w_idx;
    logic             w_col_last, w_last;

    // every window's OR uses fixed bit positions; an odd last row/column is never touched
    for (genvar r = 0; r < N; r++) begin : g_row
        for (genvar c = 0; c < N; c++) begin : g_col
            assign w_pool[r*N+c] = r_buf[(POOL_K*r)*M + POOL_K*c]
                                 | r_buf[(POOL_K*r)*M + POOL_K*c + 1]
                                 | r_buf[(POOL_K*r+1)*M + POOL_K*c]
                                 | r_buf[(POOL_K*r+1)*M + POOL_K*c + 1];
        end
    end

    // flat output index and end-of-row / end-of-map detection
    always_comb begin
        w_idx      = IW'(r_row) * IW'(N) + IW'(r_col);
        w_col_last = (r_col == CW'(N - 1));
        w_last     = w_col_last && (r_row == CW'(N - 1));
    end

    // control FSM: capture, raster-scan pool, one-cycle done pulse; a low ready aborts
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_row     <= '0;
            r_col     <= '0;
            r_buf     <= '0;
            r_img_out <= '0;
            r_dor     <= 1'b0;
            r_busy    <= 1'b0;
        end else if (!bus.data_in_ready) begin
            r_state   <= IDLE;
            r_row     <= '0;
            r_col     <= '0;
            r_img_out <= '0;
            r_dor     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_buf     <= bus.img_in;
                    r_img_out <= '0;
                    r_row     <= '0;
                    r_col     <= '0;
                    r_state   <= POOL;
                    r_busy    <= 1'b1;
                end
                POOL: begin
                    r_img_out[w_idx] <= w_pool[w_idx];
                    if (w_last) begin
                        r_row   <= '0;
                        r_col   <= '0;
                        r_state <= DONE;
                        r_dor   <= 1'b1;
                        r_busy  <= 1'b0;
                    end else if (w_col_last) begin
                        r_col <= '0;
                        r_row <= r_row + CW'(1);
                    end else begin
                        r_col <= r_col + CW'(1);
                    end
                end
                DONE: r_dor <= 1'b0;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.img_out        = r_img_out;
    assign bus.data_out_ready = r_dor;
    assign bus.busy           = r_busy;
endmodule

// File: tb/tb_bnn_maxpool_seq.sv
// tb_bnn_maxpool_seq: scoreboard bench driving a 4x4 and a 5x5 pool stage in lockstep
module tb_bnn_maxpool_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b0;
    logic [24:0] img = '0;
    int          checks = 0;
    int          errors = 0;
    logic [3:0]  q4[$];
    logic [3:0]  q5[$];

    always #5 clk = ~clk;

    bnn_maxpool_seq_if #(.M(4)) b4 ();
    bnn_maxpool_seq_if #(.M(5)) b5 ();
    assign b4.data_in_ready = rdy;
    assign b4.img_in        = img[15:0];
    assign b5.data_in_ready = rdy;
    assign b5.img_in        = img;

    bnn_maxpool_seq #(.IMG_IN_SIZE(4)) u4 (.clk(clk), .rst(rst), .bus(b4.slave));
    bnn_maxpool_seq #(.IMG_IN_SIZE(5)) u5 (.clk(clk), .rst(rst), .bus(b5.slave));

    // 2x2 stride-2 max over a +1/-1 bitmap is an OR over each window
    function automatic logic [3:0] ref_pool(input logic [24:0] v, input int m);
        logic [3:0] o;
        o = '0;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++)
                for (int dr = 0; dr < 2; dr++)
                    for (int dc = 0; dc < 2; dc++)
                        if (v[(2*r+dr)*m + 2*c+dc]) o[r*2+c] = 1'b1;
        return o;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (b4.data_out_ready === 1'b1) begin
            checks++;
            if (q4.size() == 0) begin
                errors++;
                $display("FAIL pulse4: unexpected pulse img_out=%0h at %0t", b4.img_out, $time);
            end else begin
                logic [3:0] e;
                e = q4.pop_front();
                if (b4.img_out !== e) begin
                    errors++;
                    $display("FAIL result4: got %0h expected %0h at %0t", b4.img_out, e, $time);
                end
            end
        end
        if (b5.data_out_ready === 1'b1) begin
            checks++;
            if (q5.size() == 0) begin
                errors++;
                $display("FAIL pulse5: unexpected pulse img_out=%0h at %0t", b5.img_out, $time);
            end else begin
                logic [3:0] e;
                e = q5.pop_front();
                if (b5.img_out !== e) begin
                    errors++;
                    $display("FAIL result5: got %0h expected %0h at %0t", b5.img_out, e, $time);
                end
            end
        end
    end

    task automatic chk_idle(input string name);
        chk({name, "_out4"}, 32'(b4.img_out), 0);
        chk({name, "_out5"}, 32'(b5.img_out), 0);
        chk({name, "_busy"}, {30'b0, b4.busy, b5.busy}, 0);
        chk({name, "_dor"}, {30'b0, b4.data_out_ready, b5.data_out_ready}, 0);
    endtask

    task automatic run(input logic [24:0] v, input bit rst_in_done);
        logic [3:0] e4, e5;
        int         k;
        bit         got;
        e4 = ref_pool(v, 4);
        e5 = ref_pool(v, 5);
        img = v;
        rdy = 1'b1;
        q4.push_back(e4);
        q5.push_back(e5);
        k = 0;
        got = 1'b0;
        while (k < 50 && !got) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            if (k == 1) begin
                chk("busy_after_capture", {30'b0, b4.busy, b5.busy}, 3);
                img = 25'($urandom);
            end
            got = b4.data_out_ready;
        end
        chk("latency", k, 5);
        chk("pulse_aligned", {31'b0, b5.data_out_ready}, 1);
        if (rst_in_done) begin
            rst = 1'b1;
            @(posedge clk);
            @(negedge clk);
            chk_idle("rst_done");
            rst = 1'b0;
            rdy = 1'b0;
        end else begin
            repeat (20) begin
                @(posedge clk);
                @(negedge clk);
                img = 25'($urandom);
                chk("hold4", 32'(b4.img_out), 32'(e4));
                chk("hold5", 32'(b5.img_out), 32'(e5));
                chk("hold_busy", {30'b0, b4.busy, b5.busy}, 0);
            end
            rdy = 1'b0;
            @(posedge clk);
            @(negedge clk);
            chk_idle("drop");
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [24:0] dir [6];
        dir[0] = 25'h0;
        dir[1] = 25'd1 << 5;
        dir[2] = 25'd1 << 15;
        dir[3] = 25'h000ffff;
        dir[4] = 25'd1 << 24;
        dir[5] = 25'd1 << 6;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_idle("reset");
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 6; i++) run(dir[i], 1'b0);
        // abort mid-pool at the third edge, then a clean rerun
        img = 25'h1ffffff;
        rdy = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rdy = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_idle("abort");
        run(25'h1ffffff, 1'b0);
        // reset while pooling
        img = 25'($urandom);
        rdy = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_idle("rst_pool");
        rst = 1'b0;
        rdy = 1'b0;
        @(posedge clk);
        @(negedge clk);
        run(25'($urandom), 1'b1);
        for (int i = 0; i < 20; i++) run(25'($urandom), 1'b0);
        repeat (3) @(negedge clk);
        chk("queue4_drained", q4.size(), 0);
        chk("queue5_drained", q5.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
